// File: rtl/afp_pkg.sv
// Shared AFP definitions for the normalize/pack datapath.
//   afp_word_t   : packed 5-bit AFP word {s, o[2:0], m}
//   afp_prod_t   : unpacked multiplier product {pm (Q2.2), po (offset sum), ps}
//   AFP_OFF_W    : width of the packed offset field
//   AFP_OFF_DENORM : offset code for the denormal / zero band
//   AFP_ZERO     : positive zero word
//   afp_lead_one : leading-one index of a 4-bit mantissa product
package afp_pkg;

  localparam int AFP_OFF_W = 3;
  localparam logic [AFP_OFF_W-1:0] AFP_OFF_DENORM = 3'd7;

  typedef logic [4:0] afp_word_t;

  typedef struct packed {
    logic [3:0] pm;
    logic [3:0] po;
    logic       ps;
  } afp_prod_t;

  localparam afp_word_t AFP_ZERO = {1'b0, AFP_OFF_DENORM, 1'b0};

  // Returns 0 for pm == 0; callers detect the zero product separately.
  function automatic logic [1:0] afp_lead_one(input logic [3:0] pm);
    if (pm[3])      return 2'd3;
    else if (pm[2]) return 2'd2;
    else if (pm[1]) return 2'd1;
    else            return 2'd0;
  endfunction

endpackage

// File: rtl/afp_round_pack.sv
// Combinational round-to-nearest-even and range mapping of a normalized
// product into a packed AFP word.
//   p    : leading-one index of pm
//   o    : signed internal offset before rounding (po - p + 2)
//   pm   : mantissa product, Q2.2
//   ps   : sign
//   word : packed AFP word
//   ovf  : result saturated to the largest magnitude
//   unf  : result lost precision in the denormal band or flushed to zero
module afp_round_pack
  import afp_pkg::*;
(
  input  logic              [1:0] p,
  input  logic signed       [5:0] o,
  input  logic              [3:0] pm,
  input  logic                    ps,
  output afp_word_t               word,
  output logic                    ovf,
  output logic                    unf
);

  function automatic logic rne_up(input logic r, input logic st, input logic m);
    return r & (st | m);
  endfunction

  // Packs {word, ovf, unf}; o is the post-rounding offset.
  function automatic logic [6:0] sat_pack(input logic s, input logic signed [5:0] oo,
                                          input logic m);
    if (oo < 6'sd0)       return {s, 3'b000, 1'b1, 1'b1, 1'b0};
    else if (oo <= 6'sd6) return {s, oo[2:0], m, 1'b0, 1'b0};
    else if (oo == 6'sd7) return {s, AFP_OFF_DENORM, 1'b1, 1'b0, 1'b1};
    else                  return {s, AFP_OFF_DENORM, 1'b0, 1'b0, 1'b1};
  endfunction

  logic              m_bit;
  logic              r_bit;
  logic              st_bit;
  logic              m_rnd;
  logic signed [5:0] o_rnd;

  always_comb begin
    m_bit  = 1'b0;
    r_bit  = 1'b0;
    st_bit = 1'b0;
    case (p)
      2'd3: begin
        m_bit  = pm[2];
        r_bit  = pm[1];
        st_bit = pm[0];
      end
      2'd2: begin
        m_bit = pm[1];
        r_bit = pm[0];
      end
      2'd1: m_bit = pm[0];
      default: ;
    endcase

    m_rnd = m_bit;
    o_rnd = o;
    // A carry out of the single mantissa bit bumps the exponent: the offset
    // encodes a negative exponent, so it decrements.
    if (rne_up(r_bit, st_bit, m_bit)) begin
      if (m_bit) begin
        m_rnd = 1'b0;
        o_rnd = o - 6'sd1;
      end else begin
        m_rnd = 1'b1;
      end
    end

    {word, ovf, unf} = sat_pack(ps, o_rnd, m_rnd);

    if (pm == 4'd0) begin
      word = {ps, AFP_OFF_DENORM, 1'b0};
      ovf  = 1'b0;
      unf  = 1'b0;
    end
  end

endmodule

// File: rtl/afp_normalize_pack.sv
// Normalizes, rounds and packs the AFP multiplier product into a 5-bit word
// through a 2-stage valid/ready pipeline, with sticky saturating counters of
// delivered overflow / underflow words.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake for {in_pm, in_po, in_ps}
//   out_valid/out_ready   : output handshake for {out_word, out_ovf, out_unf}
//   clr                   : clears both counters (wins over an increment)
//   ovf_cnt, unf_cnt      : saturating event counts of delivered words
module afp_normalize_pack
  import afp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_pm,
  input  logic [3:0]       in_po,
  input  logic             in_ps,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_word,
  output logic             out_ovf,
  output logic             out_unf,
  input  logic             clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic c);
    if (c)                         return '0;
    else if (inc && cnt != CNT_MAX) return cnt + CNT_ONE;
    else                           return cnt;
  endfunction

  afp_prod_t         prod_p0;
  logic        [1:0] p_p0;
  logic signed [5:0] o_p0;

  logic              vld_p1_q, vld_p1_d;
  logic        [3:0] pm_p1_q, pm_p1_d;
  logic              ps_p1_q, ps_p1_d;
  logic        [1:0] p_p1_q, p_p1_d;
  logic signed [5:0] o_p1_q, o_p1_d;

  logic              vld_p2_q, vld_p2_d;
  afp_word_t         word_p2_q, word_p2_d;
  logic              ovf_p2_q, ovf_p2_d;
  logic              unf_p2_q, unf_p2_d;

  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0]  unf_cnt_q, unf_cnt_d;

  logic              s1_load, s2_load, in_fire, out_fire;
  afp_word_t         rp_word;
  logic              rp_ovf, rp_unf;

  // ---- stage 0: leading-one detect and offset ----
  always_comb begin
    prod_p0 = '{pm: in_pm, po: in_po, ps: in_ps};
    p_p0    = afp_lead_one(prod_p0.pm);
    o_p0    = $signed({2'b00, prod_p0.po}) - $signed({4'b0000, p_p0}) + 6'sd2;
  end

  // in_ready is held low during reset so no input handshake completes then.
  assign s2_load  = !vld_p2_q | out_ready;
  assign s1_load  = !vld_p1_q | s2_load;
  assign in_ready = !reset & s1_load;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_p2_q & out_ready;

  // ---- stage 1: registered product, p and o ----
  always_comb begin
    vld_p1_d = s1_load ? in_fire : vld_p1_q;
    pm_p1_d  = in_fire ? prod_p0.pm : pm_p1_q;
    ps_p1_d  = in_fire ? prod_p0.ps : ps_p1_q;
    p_p1_d   = in_fire ? p_p0 : p_p1_q;
    o_p1_d   = in_fire ? o_p0 : o_p1_q;
  end

  afp_round_pack u_round_pack (
    .p    (p_p1_q),
    .o    (o_p1_q),
    .pm   (pm_p1_q),
    .ps   (ps_p1_q),
    .word (rp_word),
    .ovf  (rp_ovf),
    .unf  (rp_unf)
  );

  // ---- stage 2: packed result and counters ----
  always_comb begin
    vld_p2_d  = s2_load ? vld_p1_q : vld_p2_q;
    word_p2_d = word_p2_q;
    ovf_p2_d  = ovf_p2_q;
    unf_p2_d  = unf_p2_q;
    if (s2_load && vld_p1_q) begin
      word_p2_d = rp_word;
      ovf_p2_d  = rp_ovf;
      unf_p2_d  = rp_unf;
    end
    ovf_cnt_d = cnt_next(ovf_cnt_q, out_fire & ovf_p2_q, clr);
    unf_cnt_d = cnt_next(unf_cnt_q, out_fire & unf_p2_q, clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      word_p2_q <= AFP_ZERO;
      ovf_p2_q  <= 1'b0;
      unf_p2_q  <= 1'b0;
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      word_p2_q <= word_p2_d;
      ovf_p2_q  <= ovf_p2_d;
      unf_p2_q  <= unf_p2_d;
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    pm_p1_q <= pm_p1_d;
    ps_p1_q <= ps_p1_d;
    p_p1_q  <= p_p1_d;
    o_p1_q  <= o_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_word  = word_p2_q;
  assign out_ovf   = ovf_p2_q;
  assign out_unf   = unf_p2_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign unf_cnt   = unf_cnt_q;

endmodule

// File: tb/tb_afp_normalize_pack.sv
// Directed bench for afp_normalize_pack.
module tb_afp_normalize_pack;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_pm;
  logic [3:0] in_po;
  logic       in_ps;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_word;
  logic       out_ovf;
  logic       out_unf;
  logic       clr;
  logic [7:0] ovf_cnt;
  logic [7:0] unf_cnt;

  int checks = 0;
  int errors = 0;

  afp_normalize_pack #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pm     (in_pm),
    .in_po     (in_po),
    .in_ps     (in_ps),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .clr       (clr),
    .ovf_cnt   (ovf_cnt),
    .unf_cnt   (unf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one product into an empty pipe with out_ready=1 and returns the
  // delivered word; the word's handshake completes before returning.
  task automatic send_one(input logic [3:0] pm, input logic [3:0] po, input logic ps,
                          output logic [4:0] w, output logic f_ovf, output logic f_unf,
                          output int lat);
    in_pm = pm; in_po = po; in_ps = ps; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    w = out_word; f_ovf = out_ovf; f_unf = out_unf;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_pm = '0; in_po = '0; in_ps = 1'b0;
    out_ready = 1'b1; clr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_word !== 5'b01110 || out_ovf !== 1'b0 || out_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: valid=%b word=%b ovf=%b unf=%b, want 0 01110 0 0",
               out_valid, out_word, out_ovf, out_unf);
    end
    checks++;
    if (ovf_cnt !== 8'd0 || unf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: ovf_cnt=%0d unf_cnt=%0d, want 0 0", ovf_cnt, unf_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [4:0] w; logic fo, fu; int lat;
    send_one(4'b0100, 4'd3, 1'b0, w, fo, fu, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 2", lat);
    end
    checks++;
    if (w !== 5'b00110 || fo !== 1'b0 || fu !== 1'b0) begin
      errors++;
      $display("FAIL basic_word: got %b ovf=%b unf=%b want 00110 0 0", w, fo, fu);
    end
  endtask

  task automatic test_round();
    logic [4:0] w; logic fo, fu; int lat;
    send_one(4'b1001, 4'd2, 1'b1, w, fo, fu, lat);
    checks++;
    if (w !== 5'b10010 || fo !== 1'b0 || fu !== 1'b0) begin
      errors++;
      $display("FAIL round_down: got %b ovf=%b unf=%b want 10010 0 0", w, fo, fu);
    end
    send_one(4'b1111, 4'd1, 1'b0, w, fo, fu, lat);
    checks++;
    if (w !== 5'b00001 || fo !== 1'b1 || fu !== 1'b0) begin
      errors++;
      $display("FAIL round_ovf: got %b ovf=%b unf=%b want 00001 1 0", w, fo, fu);
    end
    checks++;
    if (ovf_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ovf_cnt_one: got %0d want 1", ovf_cnt);
    end
    // m=0, r=1, st=1: rounds up into m=1
    send_one(4'b1011, 4'd5, 1'b0, w, fo, fu, lat);
    checks++;
    if (w !== 5'b01001 || fo !== 1'b0 || fu !== 1'b0) begin
      errors++;
      $display("FAIL round_up_m: got %b ovf=%b unf=%b want 01001 0 0", w, fo, fu);
    end
    // tie with m=0: stays even
    send_one(4'b1010, 4'd5, 1'b0, w, fo, fu, lat);
    checks++;
    if (w !== 5'b01000 || fo !== 1'b0 || fu !== 1'b0) begin
      errors++;
      $display("FAIL round_tie_even: got %b ovf=%b unf=%b want 01000 0 0", w, fo, fu);
    end
    // tie with m=1: rounds up, carries into the offset
    send_one(4'b1110, 4'd4, 1'b0, w, fo, fu, lat);
    checks++;
    if (w !== 5'b00100 || fo !== 1'b0 || fu !== 1'b0) begin
      errors++;
      $display("FAIL round_carry: got %b ovf=%b unf=%b want 00100 0 0", w, fo, fu);
    end
    // largest normal offset
    send_one(4'b0100, 4'd6, 1'b1, w, fo, fu, lat);
    checks++;
    if (w !== 5'b11100 || fo !== 1'b0 || fu !== 1'b0) begin
      errors++;
      $display("FAIL offset_six: got %b ovf=%b unf=%b want 11100 0 0", w, fo, fu);
    end
  endtask

  task automatic test_underflow();
    logic [4:0] w; logic fo, fu; int lat;
    send_one(4'b0011, 4'd6, 1'b0, w, fo, fu, lat);
    checks++;
    if (w !== 5'b01111 || fo !== 1'b0 || fu !== 1'b1) begin
      errors++;
      $display("FAIL unf_denorm: got %b ovf=%b unf=%b want 01111 0 1", w, fo, fu);
    end
    send_one(4'b0001, 4'd6, 1'b0, w, fo, fu, lat);
    checks++;
    if (w !== 5'b01110 || fo !== 1'b0 || fu !== 1'b1) begin
      errors++;
      $display("FAIL unf_flush: got %b ovf=%b unf=%b want 01110 0 1", w, fo, fu);
    end
    send_one(4'b0000, 4'd0, 1'b1, w, fo, fu, lat);
    checks++;
    if (w !== 5'b11110 || fo !== 1'b0 || fu !== 1'b0) begin
      errors++;
      $display("FAIL zero_product: got %b ovf=%b unf=%b want 11110 0 0", w, fo, fu);
    end
    checks++;
    if (unf_cnt !== 8'd2 || ovf_cnt !== 8'd1) begin
      errors++;
      $display("FAIL unf_cnt_two: unf_cnt=%0d ovf_cnt=%0d want 2 1", unf_cnt, ovf_cnt);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pm = 4'b0100; in_po = 4'd3; in_ps = 1'b0;   // A -> 00110
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_a: got %b want 1", in_ready);
    end
    tick();
    in_pm = 4'b1001; in_po = 4'd2; in_ps = 1'b1;                     // B -> 10010
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_b: got %b want 1", in_ready);
    end
    tick();
    in_pm = 4'b0011; in_po = 4'd6; in_ps = 1'b0;                     // C -> 01111
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_full: got %b want 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_word !== 5'b00110 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold_%0d: valid=%b word=%b in_ready=%b want 1 00110 0",
                 i, out_valid, out_word, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    tick();                        // A delivered, C accepted
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_word !== 5'b10010) begin
      errors++;
      $display("FAIL b2b_order_b: valid=%b word=%b want 1 10010", out_valid, out_word);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_word !== 5'b01111 || out_unf !== 1'b1) begin
      errors++;
      $display("FAIL b2b_order_c: valid=%b word=%b unf=%b want 1 01111 1",
               out_valid, out_word, out_unf);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    int wait_cnt;
    out_ready = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (ovf_cnt !== 8'd0 || unf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_idle: ovf_cnt=%0d unf_cnt=%0d want 0 0", ovf_cnt, unf_cnt);
    end
    in_valid = 1'b1; in_pm = 4'b1111; in_po = 4'd1; in_ps = 1'b0;
    repeat (300) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (ovf_cnt !== 8'd255 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_saturate: ovf_cnt=%0d out_valid=%b want 255 0", ovf_cnt, out_valid);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_ovf !== 1'b1 || ovf_cnt !== 8'd255) begin
      errors++;
      $display("FAIL clr_setup: valid=%b ovf=%b ovf_cnt=%0d want 1 1 255",
               out_valid, out_ovf, ovf_cnt);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (ovf_cnt !== 8'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_wins: ovf_cnt=%0d out_valid=%b want 0 0", ovf_cnt, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic [4:0] w; logic fo, fu; int lat;
    bit leak;
    out_ready = 1'b1;
    send_one(4'b1000, 4'd0, 1'b0, w, fo, fu, lat);   // o=-1 -> saturates
    checks++;
    if (w !== 5'b00001 || fo !== 1'b1 || ovf_cnt !== 8'd1) begin
      errors++;
      $display("FAIL mid_setup: word=%b ovf=%b ovf_cnt=%0d want 00001 1 1", w, fo, ovf_cnt);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_pm = 4'b0100; in_po = 4'd3; in_ps = 1'b0;
    tick();
    in_pm = 4'b1001; in_po = 4'd2; in_ps = 1'b1;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_ready: got %b want 0 during reset", in_ready);
    end
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_word !== 5'b01110 || ovf_cnt !== 8'd0 || unf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b word=%b ovf_cnt=%0d unf_cnt=%0d want 0 01110 0 0",
               out_valid, out_word, ovf_cnt, unf_cnt);
    end
    out_ready = 1'b1;
    leak = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid !== 1'b0) leak = 1'b1;
    end
    checks++;
    if (leak) begin
      errors++;
      $display("FAIL mid_no_emit: got out_valid=1 after reset want 0");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_underflow();
    test_back_to_back();
    test_saturation();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
